ram_access_arbiter: RTL and testbench

- Owns the single-port record RAM (128 x 25-bit) used to buffer received orders.
- Shares that one port between three requesters:
  - the receive-side writer, which streams records in order;
  - a host random-access reader, whose reads are non-destructive;
  - a drain sequencer, which empties the buffer in FIFO order through a valid/ready stream.
- Maintains the ring pointers, the occupancy count and the status flags.

---
 rtl/ram_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Single-port record RAM arbiter: ring-buffered writer, non-destructive
// host reader and a FIFO drain sequencer share one RAM port.
`timescale 1ns/1ps
module ram_access_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 25,
  parameter int DEPTH      = 128,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_add,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              drain_start,
  output logic              drain_busy,
  output logic              drain_valid,
  input  logic              drain_ready,
  output logic [DATA_W-1:0] drain_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int SC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0]   STARVE_CAP = SC_W'(STARVE_LIM);
  localparam logic [SC_W-1:0]   SC_ONE     = SC_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_DEPTH  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, RD, WAIT, HOLD} drain_state_t;

  drain_state_t      state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] dr_ptr;
  logic [SC_W-1:0]   starve_cnt;
  logic              wr_elig;
  logic              dr_elig;
  logic              hr_elig;
  logic              rd_any;
  logic              starve_hit;
  logic              g_wr;
  logic              g_dr;
  logic              g_hr;

  assign full    = (count == CNT_DEPTH);
  assign empty   = (count == '0);
  assign wr_gnt  = g_wr;
  assign rd_gnt  = g_hr;
  assign rd_data = rd_valid ? ram_rdata : '0;

  // Grant arbitration: write > drain read > host read, with a read forced
  // through once the writer has won STARVE_LIM times in a row.
  always_comb begin
    wr_elig    = !rst && wr_req && !full;
    dr_elig    = !rst && (state == RD) && !empty;
    hr_elig    = !rst && rd_req;
    rd_any     = dr_elig || hr_elig;
    starve_hit = (starve_cnt == STARVE_CAP) && rd_any;
    g_wr       = wr_elig && !starve_hit;
    g_dr       = !g_wr && dr_elig;
    g_hr       = !g_wr && !g_dr && hr_elig;
  end

  // RAM command issued in the same cycle as the winning grant.
  always_comb begin
    ram_en    = g_wr || g_dr || g_hr;
    ram_we    = g_wr;
    ram_add   = '0;
    ram_wdata = '0;
    if (g_wr) begin
      ram_add   = wr_ptr;
      ram_wdata = wr_data;
    end else if (g_dr) begin
      ram_add = dr_ptr;
    end else if (g_hr) begin
      ram_add = rd_add;
    end
  end

  // Ring pointers, occupancy, starvation counter, sticky overflow, read valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      dr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      if (g_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      if (g_dr) dr_ptr <= (dr_ptr == PTR_LAST) ? '0 : dr_ptr + PTR_ONE;
      if (g_wr)      count <= count + CNT_ONE;
      else if (g_dr) count <= count - CNT_ONE;
      starve_cnt <= (g_wr && rd_any) ? starve_cnt + SC_ONE : '0;
      if (wr_req && full) overflow <= 1'b1;
      rd_valid <= g_hr;
    end
  end

  // Drain sequencer: fetch one record, present it, wait for ready, repeat
  // until the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drain_busy  <= 1'b0;
      drain_valid <= 1'b0;
      drain_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_start && !empty) begin
            state      <= RD;
            drain_busy <= 1'b1;
          end
        end
        RD: begin
          if (g_dr) begin
            state <= WAIT;
          end else if (empty) begin
            state      <= IDLE;
            drain_busy <= 1'b0;
          end
        end
        WAIT: begin
          drain_data  <= ram_rdata;
          drain_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (drain_ready) begin
            drain_valid <= 1'b0;
            if (!empty) begin
              state <= RD;
            end else begin
              state      <= IDLE;
              drain_busy <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          drain_busy  <= 1'b0;
          drain_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: queue/array reference model
// of the buffered records plus a behavioural RAM on the DUT's RAM port.
`timescale 1ns/1ps
module tb_ram_access_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 25;
  localparam int DEPTH      = 128;
  localparam int STARVE_LIM = 4;

  logic              clk = 1'b0;
  logic              rst, wr_req, rd_req, drain_start, drain_ready;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_add;
  logic              wr_gnt, rd_gnt, rd_valid, drain_busy, drain_valid;
  logic [DATA_W-1:0] rd_data, drain_data, ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              ram_en, ram_we, full, empty, overflow;
  logic [ADDR_W-1:0] ram_add;
  logic [ADDR_W:0]   count;

  logic [DATA_W-1:0] ram_array [DEPTH];
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  bit                mdl_vld [DEPTH];
  logic [DATA_W-1:0] mdl_q [$];
  int                mdl_wr_ptr = 0;
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  // Behavioural single-port RAM, registered read.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_array[ram_add] <= ram_wdata;
      else        ram_rdata <= ram_array[ram_add];
    end
  end

  ram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_add(rd_add), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .drain_start(drain_start), .drain_busy(drain_busy),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_data(drain_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_add(ram_add),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mdl_q.delete();
    mdl_wr_ptr = 0;
  endtask

  task automatic model_write(input logic [DATA_W-1:0] d);
    mdl_mem[mdl_wr_ptr] = d;
    mdl_vld[mdl_wr_ptr] = 1'b1;
    mdl_q.push_back(d);
    mdl_wr_ptr = (mdl_wr_ptr + 1) % DEPTH;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; drain_start = 1'b0;
    drain_ready = 1'b0; wr_data = '0; rd_add = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; drain_start = 1'b1;
    drain_ready = 1'b0; wr_data = DATA_W'($urandom); rd_add = '0;
    tick();
    #1;
    vectors++;
    if (ram_en !== 1'b0 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_grants: ram_en=%b wr_gnt=%b rd_gnt=%b, required 0 0 0", ram_en, wr_gnt, rd_gnt);
    end
    tick();
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; drain_start = 1'b0;
    #1;
    vectors++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b ovf=%b, required 0 1 0 0", count, empty, full, overflow);
    end
    vectors++;
    if (drain_busy !== 1'b0 || drain_valid !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b dvalid=%b rvalid=%b rdata=%h, required 0 0 0 0", drain_busy, drain_valid, rd_valid, rd_data);
    end
    model_reset();
  endtask

  task automatic test_writes(input int n);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DATA_W'($urandom);
      wr_req = 1'b1; wr_data = d;
      #1;
      vectors++;
      if (wr_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1) begin
        miscompares++;
        $display("FAIL write_grant[%0d]: wr_gnt=%b ram_en=%b ram_we=%b, required 1 1 1", i, wr_gnt, ram_en, ram_we);
      end
      vectors++;
      if (ram_add !== ADDR_W'(mdl_wr_ptr) || ram_wdata !== d) begin
        miscompares++;
        $display("FAIL write_cmd[%0d]: add=%0d data=%h, required %0d %h", i, ram_add, ram_wdata, mdl_wr_ptr, d);
      end
      model_write(d);
      tick();
    end
    wr_req = 1'b0;
    #1;
    vectors++;
    if (count !== (ADDR_W + 1)'(mdl_q.size()) || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL write_count: count=%0d empty=%b, required %0d 0", count, empty, mdl_q.size());
    end
  endtask

  task automatic test_host_read();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? ADDR_W'(1) : ADDR_W'($urandom_range(2));
      rd_req = 1'b1; rd_add = a;
      #1;
      vectors++;
      if (rd_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_add !== a) begin
        miscompares++;
        $display("FAIL host_read_cmd: gnt=%b en=%b we=%b add=%0d, required 1 1 0 %0d", rd_gnt, ram_en, ram_we, ram_add, a);
      end
      tick();
      rd_req = 1'b0;
      #1;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== mdl_mem[a]) begin
        miscompares++;
        $display("FAIL host_read_data: valid=%b data=%h, required 1 %h", rd_valid, rd_data, mdl_mem[a]);
      end
      vectors++;
      if (count !== (ADDR_W + 1)'(mdl_q.size())) begin
        miscompares++;
        $display("FAIL host_read_count: count=%0d, required %0d", count, mdl_q.size());
      end
      tick();
      vectors++;
      if (rd_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL host_read_pulse: rd_valid=%b, required 0", rd_valid);
      end
    end
  endtask

  // Random writer/host reader/drain consumer against the queue model.
  task automatic run_mixed(input int n_wr, input int n_rd, input int ready_pct, input int budget);
    logic [DATA_W-1:0] exp_d, exp_rd;
    bit have_d, rv_due, rv_known, g_w, g_r;
    int guard;
    have_d = 0; rv_due = 0; rv_known = 0; guard = 0; exp_d = '0; exp_rd = '0;
    while ((drain_busy || wr_req || rd_req || rv_due || n_wr > 0 || n_rd > 0) && guard < budget) begin
      if (!wr_req && n_wr > 0 && $urandom_range(2) == 0) begin
        wr_req = 1'b1; wr_data = DATA_W'($urandom); n_wr--;
      end
      if (!rd_req && n_rd > 0 && $urandom_range(3) == 0) begin
        rd_req = 1'b1; rd_add = ADDR_W'($urandom_range(DEPTH - 1)); n_rd--;
      end
      drain_ready = ($urandom_range(99) < ready_pct);
      #1;
      g_w = wr_gnt; g_r = rd_gnt;
      vectors++;
      if (rd_valid !== rv_due) begin
        miscompares++;
        $display("FAIL mix_rd_valid: rd_valid=%b, required %b", rd_valid, rv_due);
      end
      if (rv_due && rv_known) begin
        vectors++;
        if (rd_data !== exp_rd) begin
          miscompares++;
          $display("FAIL mix_rd_data: data=%h, required %h", rd_data, exp_rd);
        end
      end
      rv_due = 0;
      vectors++;
      if (g_w && g_r) begin
        miscompares++;
        $display("FAIL mix_exclusive: wr_gnt=%b rd_gnt=%b, required not both", g_w, g_r);
      end
      if (!drain_busy && !wr_req && rd_req) begin
        vectors++;
        if (g_r !== 1'b1) begin
          miscompares++;
          $display("FAIL mix_read_idle: rd_gnt=%b, required 1", g_r);
        end
      end
      if (!drain_busy && wr_req && !rd_req) begin
        vectors++;
        if (g_w !== (mdl_q.size() < DEPTH)) begin
          miscompares++;
          $display("FAIL mix_write_idle: wr_gnt=%b, required %b", g_w, mdl_q.size() < DEPTH);
        end
      end
      if (g_w) begin
        vectors++;
        if (!wr_req || ram_we !== 1'b1 || ram_add !== ADDR_W'(mdl_wr_ptr) || ram_wdata !== wr_data) begin
          miscompares++;
          $display("FAIL mix_write: we=%b add=%0d data=%h, required 1 %0d %h", ram_we, ram_add, ram_wdata, mdl_wr_ptr, wr_data);
        end
        model_write(wr_data);
      end
      if (g_r) begin
        vectors++;
        if (!rd_req || ram_we !== 1'b0 || ram_add !== rd_add) begin
          miscompares++;
          $display("FAIL mix_read: we=%b add=%0d, required 0 %0d", ram_we, ram_add, rd_add);
        end
        rv_due = 1; rv_known = mdl_vld[rd_add]; exp_rd = mdl_mem[rd_add];
      end
      if (drain_valid) begin
        if (!have_d) begin
          vectors++;
          if (mdl_q.size() == 0) begin
            miscompares++;
            $display("FAIL mix_drain_extra: data=%h, required no record", drain_data);
          end else begin
            exp_d = mdl_q.pop_front();
            have_d = 1;
          end
        end
        if (have_d) begin
          vectors++;
          if (drain_data !== exp_d) begin
            miscompares++;
            $display("FAIL mix_drain_data: data=%h, required %h", drain_data, exp_d);
          end
          if (drain_ready) have_d = 0;
        end
      end
      @(posedge clk);
      #1;
      if (g_w) wr_req = 1'b0;
      if (g_r) rd_req = 1'b0;
      guard++;
    end
    vectors++;
    if (guard >= budget) begin
      miscompares++;
      $display("FAIL mix_timeout: %0d cycles, required < %0d", guard, budget);
    end
    drain_ready = 1'b0;
  endtask

  task automatic test_drain();
    logic [DATA_W-1:0] exp;
    int g;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    #1;
    vectors++;
    if (drain_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_busy_set: busy=%b, required 1", drain_busy);
    end
    g = 0;
    while (!drain_valid && g < 10) begin
      tick();
      g++;
    end
    vectors++;
    if (drain_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_first_valid: valid=%b after %0d cycles, required 1", drain_valid, g);
    end
    exp = mdl_q.pop_front();
    vectors++;
    if (drain_data !== exp || count !== (ADDR_W + 1)'(mdl_q.size())) begin
      miscompares++;
      $display("FAIL drain_first: data=%h count=%0d, required %h %0d", drain_data, count, exp, mdl_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (drain_valid !== 1'b1 || drain_data !== exp) begin
        miscompares++;
        $display("FAIL drain_hold[%0d]: valid=%b data=%h, required 1 %h", i, drain_valid, drain_data, exp);
      end
    end
    drain_ready = 1'b1;
    tick();
    run_mixed(0, 0, 100, 60);
    #1;
    vectors++;
    if (drain_busy !== 1'b0 || count !== '0 || empty !== 1'b1 || mdl_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_done: busy=%b count=%0d empty=%b left=%0d, required 0 0 1 0", drain_busy, count, empty, mdl_q.size());
    end
  endtask

  task automatic test_starvation();
    logic [DATA_W-1:0] d, exp;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      rd_req = 1'b1;
      rd_add = (r == 0) ? '0 : ADDR_W'($urandom_range(mdl_wr_ptr - 1));
      wr_req = 1'b1;
      for (int c = 0; c < STARVE_LIM; c++) begin
        d = DATA_W'($urandom); wr_data = d;
        #1;
        vectors++;
        if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || ram_add !== ADDR_W'(mdl_wr_ptr)) begin
          miscompares++;
          $display("FAIL starve_write[%0d.%0d]: wr_gnt=%b rd_gnt=%b add=%0d, required 1 0 %0d", r, c, wr_gnt, rd_gnt, ram_add, mdl_wr_ptr);
        end
        model_write(d);
        tick();
      end
      d = DATA_W'($urandom); wr_data = d;
      #1;
      vectors++;
      if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0 || ram_add !== rd_add) begin
        miscompares++;
        $display("FAIL starve_read[%0d]: rd_gnt=%b wr_gnt=%b add=%0d, required 1 0 %0d", r, rd_gnt, wr_gnt, ram_add, rd_add);
      end
      exp = mdl_mem[rd_add];
      tick();
      rd_req = 1'b0;
      #1;
      vectors++;
      if (wr_gnt !== 1'b1 || rd_valid !== 1'b1 || rd_data !== exp) begin
        miscompares++;
        $display("FAIL starve_resume[%0d]: wr_gnt=%b rvalid=%b data=%h, required 1 1 %h", r, wr_gnt, rd_valid, rd_data, exp);
      end
      model_write(d);
      tick();
      d = DATA_W'($urandom); wr_data = d;
      #1;
      vectors++;
      if (wr_gnt !== 1'b1) begin
        miscompares++;
        $display("FAIL starve_tail[%0d]: wr_gnt=%b, required 1", r, wr_gnt);
      end
      model_write(d);
      tick();
    end
    wr_req = 1'b0;
    #1;
    vectors++;
    if (count !== (ADDR_W + 1)'(mdl_q.size())) begin
      miscompares++;
      $display("FAIL starve_count: count=%0d, required %0d", count, mdl_q.size());
    end
  endtask

  task automatic test_fill();
    do_reset();
    test_writes(DEPTH);
    wr_req = 1'b1; wr_data = DATA_W'($urandom);
    #1;
    vectors++;
    if (full !== 1'b1 || overflow !== 1'b0 || wr_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: full=%b ovf=%b wr_gnt=%b, required 1 0 0", full, overflow, wr_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (wr_gnt !== 1'b0 || overflow !== 1'b1 || count !== (ADDR_W + 1)'(DEPTH)) begin
        miscompares++;
        $display("FAIL fill_hold[%0d]: wr_gnt=%b ovf=%b count=%0d, required 0 1 %0d", i, wr_gnt, overflow, count, DEPTH);
      end
    end
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    run_mixed(24, 12, 60, 4000);
    #1;
    vectors++;
    if (count !== (ADDR_W + 1)'(mdl_q.size()) || empty !== (mdl_q.size() == 0) || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_end: count=%0d empty=%b ovf=%b, required %0d %b 1", count, empty, overflow, mdl_q.size(), mdl_q.size() == 0);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    test_writes(3);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    #1;
    vectors++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_add !== '0 || rd_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_drain_grant: en=%b we=%b add=%0d rd_gnt=%b, required 1 0 0 0", ram_en, ram_we, ram_add, rd_gnt);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (drain_busy !== 1'b0 || drain_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_drain_reset: busy=%b valid=%b count=%0d empty=%b, required 0 0 0 1", drain_busy, drain_valid, count, empty);
    end
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    #1;
    vectors++;
    if (drain_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_start: busy=%b, required 0", drain_busy);
    end
    tick();
    vectors++;
    if (drain_valid !== 1'b0 || ram_en !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_start_idle: valid=%b ram_en=%b, required 0 0", drain_valid, ram_en);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_vld[i] = 1'b0;
    test_reset();
    test_writes(3);
    test_host_read();
    test_drain();
    test_starvation();
    test_fill();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
